// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor: decodes a sampled Johnson count to phase/one-hot, checks
// successor ordering, tracks lock and counts revolutions and sequence errors.
module johnson_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int PW      = $clog2(2*WIDTH),
    localparam int SW      = $clog2(LOCK_CNT+1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [WIDTH-1:0]   count_i,
    output logic [PW-1:0]      phase_o,
    output logic [2*WIDTH-1:0] onehot_o,
    output logic               legal_o,
    output logic               locked_o,
    output logic               seq_err_o,
    output logic               wrap_o,
    output logic [15:0]        rev_cnt_o,
    output logic [ERR_W-1:0]   err_cnt_o
);
    typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} state_e;

    state_e               state_q;
    logic [SW-1:0]        streak_q;
    logic [PW-1:0]        phase_q, phase_d, next_phase;
    logic [2*WIDTH-1:0]   onehot_q, onehot_d;
    logic                 legal_q, legal_d, seq_err_q, wrap_q, succ, stall;
    logic [15:0]          rev_q;
    logic [ERR_W-1:0]     err_q;
    int                   trans, ones;

    // A Johnson code has at most one edge between adjacent bits; the number of
    // ones plus the MSB tells which half of the revolution we are in.
    always_comb begin
        trans = 0;
        for (int i = 0; i < WIDTH-1; i++) trans += int'(count_i[i] ^ count_i[i+1]);
        ones       = $countones(count_i);
        legal_d    = trans <= 1;
        phase_d    = count_i[WIDTH-1] ? PW'(ones) : (ones == 0 ? '0 : PW'(2*WIDTH-ones));
        onehot_d   = '0;
        onehot_d[phase_d] = 1'b1;
        next_phase = (phase_q == PW'(2*WIDTH-1)) ? '0 : phase_q + 1'b1;
        succ       = phase_d == next_phase;
        stall      = phase_d == phase_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= UNLOCK;
            streak_q  <= '0;
            phase_q   <= '0;
            onehot_q  <= '0;
            legal_q   <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            rev_q     <= '0;
            err_q     <= '0;
        end else begin
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            if (clr_i) begin
                state_q  <= UNLOCK;
                streak_q <= '0;
                rev_q    <= '0;
                err_q    <= '0;
            end else if (en_i) begin
                legal_q  <= legal_d;
                onehot_q <= legal_d ? onehot_d : '0;
                if (legal_d) phase_q <= phase_d;
                case (state_q)
                    UNLOCK: if (legal_d) begin
                        state_q  <= ACQ;
                        streak_q <= '0;
                    end
                    ACQ: if (!legal_d) begin
                        state_q <= UNLOCK;
                    end else if (succ) begin
                        streak_q <= streak_q + 1'b1;
                        if (streak_q == SW'(LOCK_CNT-1)) state_q <= LOCKED;
                    end else if (!stall) begin
                        streak_q <= '0;
                    end
                    default: if (!legal_d || !(succ || stall)) begin
                        seq_err_q <= 1'b1;
                        if (err_q != '1) err_q <= err_q + 1'b1;
                        state_q  <= legal_d ? ACQ : UNLOCK;
                        streak_q <= '0;
                    end else if (succ && phase_q == PW'(2*WIDTH-1)) begin
                        wrap_q <= 1'b1;
                        rev_q  <= rev_q + 1'b1;
                    end
                endcase
            end
        end
    end

    assign phase_o   = phase_q;
    assign onehot_o  = onehot_q;
    assign legal_o   = legal_q;
    assign locked_o  = state_q == LOCKED;
    assign seq_err_o = seq_err_q;
    assign wrap_o    = wrap_q;
    assign rev_cnt_o = rev_q;
    assign err_cnt_o = err_q;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor: directed lock/wrap/error/saturation scenarios followed by
// randomized traffic, all checked against a table-driven reference model.
module tb_johnson_phase_monitor;
    localparam int N = 4, L = 3, P = 2*N;

    logic       clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, clr_i = 1'b0;
    logic [3:0] count_i = '0;
    logic [2:0] phase_o;
    logic [7:0] onehot_o, err_cnt_o;
    logic       legal_o, locked_o, seq_err_o, wrap_o;
    logic [15:0] rev_cnt_o;

    johnson_phase_monitor #(.WIDTH(N), .LOCK_CNT(L), .ERR_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i), .count_i(count_i),
        .phase_o(phase_o), .onehot_o(onehot_o), .legal_o(legal_o), .locked_o(locked_o),
        .seq_err_o(seq_err_o), .wrap_o(wrap_o), .rev_cnt_o(rev_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_fail = 0;
    logic [3:0] codes [P];
    int m_phase, m_state, m_streak, m_rev, m_err, cur;
    bit m_legal, m_seq, m_wrap;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int lookup(logic [3:0] c);
        for (int i = 0; i < P; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_state = 0; m_streak = 0; m_rev = 0; m_err = 0;
        m_legal = 0; m_seq = 0; m_wrap = 0;
    endtask

    task automatic model_err();
        m_seq = 1;
        if (m_err < 255) m_err++;
    endtask

    // state: 0 = unlocked, 1 = acquiring, 2 = locked
    task automatic model_step(bit en, bit clr, logic [3:0] c);
        int idx;
        bit succ, stall;
        m_seq = 0; m_wrap = 0;
        if (clr) begin
            m_state = 0; m_streak = 0; m_rev = 0; m_err = 0;
        end else if (en) begin
            idx   = lookup(c);
            succ  = idx >= 0 && idx == (m_phase + 1) % P;
            stall = idx >= 0 && idx == m_phase;
            if (idx < 0) begin
                if (m_state == 2) model_err();
                m_state = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_streak = 0;
            end else if (m_state == 1) begin
                if (succ) begin
                    m_streak++;
                    if (m_streak == L) m_state = 2;
                end else if (!stall) m_streak = 0;
            end else begin
                if (succ && m_phase == P-1) begin
                    m_wrap = 1; m_rev = (m_rev + 1) % 65536;
                end else if (!succ && !stall) begin
                    model_err(); m_state = 1; m_streak = 0;
                end
            end
            m_legal = idx >= 0;
            if (idx >= 0) m_phase = idx;
        end
    endtask

    task automatic check_all();
        check("phase", 32'(phase_o), 32'(m_phase));
        check("onehot", 32'(onehot_o), m_legal ? 32'(1) << m_phase : 32'(0));
        check("legal", 32'(legal_o), 32'(m_legal));
        check("locked", 32'(locked_o), 32'(m_state == 2));
        check("seq_err", 32'(seq_err_o), 32'(m_seq));
        check("wrap", 32'(wrap_o), 32'(m_wrap));
        check("rev_cnt", 32'(rev_cnt_o), 32'(m_rev));
        check("err_cnt", 32'(err_cnt_o), 32'(m_err));
    endtask

    task automatic cyc(bit en, bit clr, logic [3:0] c);
        @(negedge clk_i);
        en_i = en; clr_i = clr; count_i = c;
        @(posedge clk_i);
        model_step(en, clr, c);
        #1 check_all();
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 model_reset();
        check_all();
        check("rst_locked", 32'(locked_o), 32'(0));
        @(negedge clk_i) rst_ni = 1'b1;
    endtask

    task automatic relock();
        cyc(1, 0, 4'b0000); cyc(1, 0, 4'b1000); cyc(1, 0, 4'b1100); cyc(1, 0, 4'b1110);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] c;
        int r;
        bit en, clr;
        c = '0;
        for (int i = 0; i < P; i++) begin
            codes[i] = c;
            c = {~c[0], c[3:1]};
        end
        model_reset();
        #2 check_all();
        @(negedge clk_i) rst_ni = 1'b1;

        cyc(1, 0, 4'b0000);
        check("t1_onehot", 32'(onehot_o), 32'h01);
        check("t1_legal", 32'(legal_o), 32'd1);
        cyc(1, 0, 4'b1000); cyc(1, 0, 4'b1100);
        check("t2_locked_early", 32'(locked_o), 32'd0);
        cyc(1, 0, 4'b1110);
        check("t2_phase", 32'(phase_o), 32'd3);
        check("t2_locked", 32'(locked_o), 32'd1);
        cyc(1, 0, 4'b1110);
        check("t2_stall_locked", 32'(locked_o), 32'd1);
        check("t2_stall_err", 32'(seq_err_o), 32'd0);
        cyc(0, 0, 4'b1010);
        check("t2_en0_legal", 32'(legal_o), 32'd1);
        cyc(1, 0, 4'b1111); cyc(1, 0, 4'b0111); cyc(1, 0, 4'b0011); cyc(1, 0, 4'b0001);
        check("t3_phase7", 32'(phase_o), 32'd7);
        cyc(1, 0, 4'b0000);
        check("t3_wrap", 32'(wrap_o), 32'd1);
        check("t3_rev", 32'(rev_cnt_o), 32'd1);
        cyc(0, 0, 4'b1000);
        check("t3_wrap_pulse", 32'(wrap_o), 32'd0);

        cyc(1, 0, 4'b1010);
        check("t4_legal", 32'(legal_o), 32'd0);
        check("t4_onehot", 32'(onehot_o), 32'd0);
        check("t4_seq_err", 32'(seq_err_o), 32'd1);
        check("t4_err", 32'(err_cnt_o), 32'd1);
        check("t4_phase_hold", 32'(phase_o), 32'd0);
        relock();
        check("t4_relock", 32'(locked_o), 32'd1);

        cyc(1, 0, 4'b1100);
        check("t5_seq_err", 32'(seq_err_o), 32'd1);
        cyc(1, 0, 4'b1111);
        check("t5_phase", 32'(phase_o), 32'd4);
        check("t5_locked", 32'(locked_o), 32'd0);
        check("t5_err", 32'(err_cnt_o), 32'd2);
        cyc(1, 0, 4'b0111); cyc(1, 0, 4'b0011); cyc(1, 0, 4'b0001);
        check("t5_relock", 32'(locked_o), 32'd1);

        for (int i = 0; i < 260; i++) begin
            cyc(1, 0, 4'b0110);
            relock();
        end
        check("t6_sat", 32'(err_cnt_o), 32'd255);
        cyc(1, 0, 4'b1010);
        check("t6_sat_pulse", 32'(seq_err_o), 32'd1);
        check("t6_sat_hold", 32'(err_cnt_o), 32'd255);
        relock();
        cyc(1, 1, 4'b1000);
        check("t6_clr_err", 32'(err_cnt_o), 32'd0);
        check("t6_clr_locked", 32'(locked_o), 32'd0);
        check("t6_clr_phase", 32'(phase_o), 32'd3);
        check("t6_clr_seq", 32'(seq_err_o), 32'd0);

        cur = m_phase;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                async_reset();
                cur = 0;
            end
            r   = $urandom_range(99);
            en  = $urandom_range(9) != 0;
            clr = $urandom_range(99) == 0;
            if (r < 65) begin
                cur = (cur + 1) % P; c = codes[cur];
            end else if (r < 75) begin
                c = codes[cur];
            end else if (r < 88) begin
                cur = $urandom_range(P-1); c = codes[cur];
            end else begin
                c = 4'($urandom_range(15));
            end
            cyc(en, clr, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
